// File: rtl/bus_master_port_pkg.sv
// Shared definitions for the processor data-bus initiator.
//   state_t           : FSM encoding (IDLE / ACCESS / RESP)
//   IO_SEL_BIT        : address bit that selects I/O devices instead of data memory
//   DEFAULT_PARK_ADDR : address driven while the bus is idle (I/O space, so
//                       data memory never drives dbus when nothing is going on)
package bus_master_port_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int          IO_SEL_BIT        = 28;
  localparam logic [31:0] DEFAULT_PARK_ADDR = 32'h1000_0000;

endpackage

// File: rtl/bus_master_port.sv
// Initiator side of the shared processor data bus.
// Accepts one load/store from the CPU (req_* valid/ready), runs it on the
// bus for 1+WAIT_CYCLES cycles, then returns a response (resp_* valid/ready).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/ready/we/addr/wdata : CPU request handshake
//   resp_valid/ready/rdata     : CPU response handshake (rdata=0 for stores)
//   addr, wrtEn                : bus address / write enable (sole driver)
//   dbus                       : shared tri-state data bus
// All outputs, including the dbus driver enable, come straight from flops.
module bus_master_port
  import bus_master_port_pkg::*;
#(
  parameter int ADDR_BIT_WIDTH = 32,
  parameter int DATA_BIT_WIDTH = 32,
  parameter int WAIT_CYCLES    = 0,
  parameter logic [ADDR_BIT_WIDTH-1:0] PARK_ADDR = ADDR_BIT_WIDTH'(DEFAULT_PARK_ADDR)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_BIT_WIDTH-1:0] req_addr,
  input  logic [DATA_BIT_WIDTH-1:0] req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_BIT_WIDTH-1:0] resp_rdata,
  output logic [ADDR_BIT_WIDTH-1:0] addr,
  output logic                      wrtEn,
  inout  wire  [DATA_BIT_WIDTH-1:0] dbus
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // The park address must point at I/O space or data memory would answer
  // (and drive dbus) while the bus is idle.
  if (ADDR_BIT_WIDTH > IO_SEL_BIT) begin : g_park_chk
    if (!PARK_ADDR[IO_SEL_BIT]) begin : g_park_err
      $error("PARK_ADDR must have the I/O select bit set");
    end
  end

  state_t                    r_state, w_state;
  logic                      r_req_ready, w_req_ready;
  logic                      r_resp_valid, w_resp_valid;
  logic [DATA_BIT_WIDTH-1:0] r_resp_rdata, w_resp_rdata;
  logic [ADDR_BIT_WIDTH-1:0] r_addr, w_addr;
  logic                      r_wrt_en, w_wrt_en;
  logic                      r_drive_en, w_drive_en;
  logic [DATA_BIT_WIDTH-1:0] r_wdata, w_wdata;
  logic [3:0]                r_wait_cnt, w_wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_addr       <= PARK_ADDR;
      r_wrt_en     <= 1'b0;
      r_drive_en   <= 1'b0;
      r_wdata      <= '0;
      r_wait_cnt   <= '0;
    end else begin
      r_state      <= w_state;
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_addr       <= w_addr;
      r_wrt_en     <= w_wrt_en;
      r_drive_en   <= w_drive_en;
      r_wdata      <= w_wdata;
      r_wait_cnt   <= w_wait_cnt;
    end
  end

  // drive_en and wrtEn always move together, so the master can only own
  // dbus while responders are told to stay off it.
  always_comb begin
    w_state      = r_state;
    w_req_ready  = r_req_ready;
    w_resp_valid = r_resp_valid;
    w_resp_rdata = r_resp_rdata;
    w_addr       = r_addr;
    w_wrt_en     = r_wrt_en;
    w_drive_en   = r_drive_en;
    w_wdata      = r_wdata;
    w_wait_cnt   = r_wait_cnt;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state     = ACCESS;
          w_req_ready = 1'b0;
          w_addr      = req_addr;
          w_wrt_en    = req_we;
          w_drive_en  = req_we;
          w_wdata     = req_wdata;
          w_wait_cnt  = WAIT_INIT;
        end
      end
      ACCESS: begin
        if (r_wait_cnt != 4'd0) begin
          w_wait_cnt = r_wait_cnt - 4'd1;
        end else begin
          // Last bus cycle: sample read data (the responder commits a
          // store on this same edge), then park the bus.
          w_resp_rdata = r_wrt_en ? '0 : dbus;
          w_wrt_en     = 1'b0;
          w_drive_en   = 1'b0;
          w_addr       = PARK_ADDR;
          w_resp_valid = 1'b1;
          w_state      = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_resp_valid = 1'b0;
          w_req_ready  = 1'b1;
          w_state      = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign dbus       = r_drive_en ? r_wdata : 'z;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign addr       = r_addr;
  assign wrtEn      = r_wrt_en;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: two instances (WAIT_CYCLES=0 and 3), each on its
// own bus with a 16-word data memory at addresses 0..15 and an I/O device that
// answers the park address with a fixed pattern (so a released dbus reads as
// that pattern and any master drive outside a store is visible).
module tb_bus_master_port;

  localparam logic [31:0] PARK   = 32'h1000_0000;
  localparam logic [31:0] IO_PAT = 32'h0000_0001;
  localparam int          W0 = 0;
  localparam int          W1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rv[2], rwe[2], rr[2];
  logic [31:0] ra[2], rd[2];
  logic rdy[2], vld[2], we_b[2];
  logic [31:0] rdat[2], ab[2];
  wire  [31:0] dbus0, dbus1;
  logic [31:0] mem0[16];
  logic [31:0] mem1[16];
  logic [31:0] mdl[2][16];
  logic rrf[2], rrv[2];
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   fails = 0;

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rdata;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  bus_master_port #(.WAIT_CYCLES(W0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(rwe[0]), .req_addr(ra[0]), .req_wdata(rd[0]),
    .resp_valid(vld[0]), .resp_ready(rr[0]), .resp_rdata(rdat[0]),
    .addr(ab[0]), .wrtEn(we_b[0]), .dbus(dbus0)
  );

  bus_master_port #(.WAIT_CYCLES(W1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(rwe[1]), .req_addr(ra[1]), .req_wdata(rd[1]),
    .resp_valid(vld[1]), .resp_ready(rr[1]), .resp_rdata(rdat[1]),
    .addr(ab[1]), .wrtEn(we_b[1]), .dbus(dbus1)
  );

  function automatic logic [31:0] init_val(input int l, input int i);
    if (l == 1 && i == 7) return 32'h0000_1234;
    return 32'hA000_0000 | 32'(l << 8) | 32'(i);
  endfunction

  // Responders: data memory (addr 0..15) and the I/O device at bit 28.
  assign dbus0 = (!we_b[0] && ab[0][31:4] == 28'd0) ? mem0[ab[0][3:0]] : 'z;
  assign dbus0 = (!we_b[0] && ab[0][28]) ? IO_PAT : 'z;
  assign dbus1 = (!we_b[1] && ab[1][31:4] == 28'd0) ? mem1[ab[1][3:0]] : 'z;
  assign dbus1 = (!we_b[1] && ab[1][28]) ? IO_PAT : 'z;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem0[i] <= init_val(0, i);
        mem1[i] <= init_val(1, i);
      end
    end else begin
      if (we_b[0] && ab[0][31:4] == 28'd0) mem0[ab[0][3:0]] <= dbus0;
      if (we_b[1] && ab[1][31:4] == 28'd0) mem1[ab[1][3:0]] <= dbus1;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // resp_ready: random unless forced by the directed back-pressure test.
  initial begin
    rr[0] = 1'b0;
    rr[1] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) rr[l] = rrf[l] ? rrv[l] : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: phase per lane (idle -> 1+W bus cycles -> response until taken).
  initial begin
    int   ph[2];
    int   cnt[2];
    exp_t e;
    logic [31:0] db;
    bit   have;
    ph[0] = 0; ph[1] = 0; cnt[0] = 0; cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        db   = (l == 0) ? dbus0 : dbus1;
        have = (l == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) e = (l == 0) ? q0[0] : q1[0];
        if (!mon_en) begin
          ph[l] = 0;
        end else begin
          case (ph[l])
            0: begin
              chk($sformatf("idle_l%0d", l), {rdy[l], vld[l], we_b[l], ab[l]}, {1'b1, 1'b0, 1'b0, PARK});
              chk($sformatf("idle_dbus_l%0d", l), db, IO_PAT);
              if (rv[l] && rdy[l]) begin
                ph[l]  = 1;
                cnt[l] = (l == 0) ? W0 + 1 : W1 + 1;
              end
            end
            1: begin
              chk($sformatf("sb_nonempty_l%0d", l), have, 1'b1);
              if (have) begin
                chk($sformatf("bus_l%0d", l), {rdy[l], vld[l], we_b[l], ab[l]}, {1'b0, 1'b0, e.we, e.a});
                if (e.we) chk($sformatf("store_dbus_l%0d", l), db, e.d);
                cnt[l]--;
                if (cnt[l] == 0) ph[l] = 2;
              end
            end
            default: begin
              chk($sformatf("sb_nonempty_l%0d", l), have, 1'b1);
              if (have) begin
                chk($sformatf("resp_l%0d", l), {rdy[l], vld[l], we_b[l], ab[l], rdat[l]},
                    {1'b0, 1'b1, 1'b0, PARK, e.rdata});
                chk($sformatf("resp_dbus_l%0d", l), db, IO_PAT);
                if (rr[l]) begin
                  if (l == 0) void'(q0.pop_front());
                  else void'(q1.pop_front());
                  ph[l] = 0;
                end
              end
            end
          endcase
        end
      end
    end
  end

  task automatic issue(input int l, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    rv[l] = 1'b1; rwe[l] = we; ra[l] = a; rd[l] = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy[l]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("accept_l%0d", l), ok, 1'b1);
    if (ok) begin
      exp_t e;
      e.we = we; e.a = a; e.d = d;
      e.rdata = we ? 32'h0 : mdl[l][a[3:0]];
      if (we) mdl[l][a[3:0]] = d;
      if (l == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble the request after acceptance; it must not matter.
    rv[l] = 1'b0; rwe[l] = 1'($urandom_range(0, 1)); ra[l] = $urandom; rd[l] = $urandom;
  endtask

  task automatic wait_idle(input int l);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (((l == 0) ? q0.size() : q1.size()) == 0 && rdy[l]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("drain_l%0d", l), ok, 1'b1);
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < 16; i++) mdl[l][i] = init_val(l, i);
  endtask

  initial begin
    for (int l = 0; l < 2; l++) begin
      rv[l] = 1'b0; rwe[l] = 1'b0; ra[l] = '0; rd[l] = '0; rrf[l] = 1'b0; rrv[l] = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    for (int l = 0; l < 2; l++)
      chk($sformatf("reset_l%0d", l), {rdy[l], vld[l], rdat[l], we_b[l], ab[l]},
          {1'b1, 1'b0, 32'h0, 1'b0, PARK});
    chk("reset_dbus_l0", dbus0, IO_PAT);
    chk("reset_dbus_l1", dbus1, IO_PAT);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;

    // No-wait lane: store then load back.
    issue(0, 1'b1, 32'd5, 32'hDEADBEEF);
    issue(0, 1'b0, 32'd5, 32'h0);
    wait_idle(0);
    chk("mem0_5", mem0[5], 32'hDEADBEEF);

    // Wait-state lane: preloaded word, then back-pressure with a queued request.
    issue(1, 1'b0, 32'd7, 32'h0);
    wait_idle(1);
    rrf[1] = 1'b1;
    rrv[1] = 1'b0;
    issue(1, 1'b1, 32'd3, 32'hCAFEF00D);
    fork
      begin
        repeat (9) @(posedge clk);
        #1 rrv[1] = 1'b1;
      end
      issue(1, 1'b0, 32'd3, 32'h0);
    join
    rrf[1] = 1'b0;
    wait_idle(1);

    // Random load/store mix on both lanes at once.
    fork
      begin
        for (int k = 0; k < 40; k++)
          issue(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
      end
      begin
        for (int k = 0; k < 25; k++)
          issue(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
      end
    join
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("mem0_%0d", i), mem0[i], mdl[0][i]);
      chk($sformatf("mem1_%0d", i), mem1[i], mdl[1][i]);
    end

    // Reset in the middle of a wait-stated store.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    rv[1] = 1'b1; rwe[1] = 1'b1; ra[1] = 32'd9; rd[1] = 32'h5555AAAA;
    @(posedge clk);
    #1 rv[1] = 1'b0;
    @(posedge clk);
    #3;
    chk("pre_rst_wrtEn", we_b[1], 1'b1);
    chk("pre_rst_dbus", dbus1, 32'h5555AAAA);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {we_b[1], ab[1], rdy[1], vld[1]}, {1'b0, PARK, 1'b1, 1'b0});
    chk("rst_dbus", dbus1, IO_PAT);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy[1], 1'b1);
    issue(1, 1'b0, 32'd9, 32'h0);
    issue(0, 1'b0, 32'd2, 32'h0);
    wait_idle(1);
    wait_idle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
